// File: rtl/cache_fill_ctrl.sv
// Miss and write-through controller sharing one 16-bit memory port between the
// I-cache and the D-cache: block refills (pipelined burst) and D-cache stores.
module cache_fill_ctrl #(
   parameter int BLOCK_WORDS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        icache_miss,
   input  logic [15:0] icache_addr,
   input  logic        dcache_miss,
   input  logic        dcache_rd,
   input  logic        dcache_wr,
   input  logic [15:0] dcache_addr,
   input  logic [15:0] dcache_wdata,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_data_in,
   input  logic        mem_data_valid,
   output logic [15:0] fill_addr,
   output logic [15:0] fill_data,
   output logic        i_load_data,
   output logic        i_load_tag,
   output logic        d_load_data,
   output logic        d_load_tag,
   output logic        i_stall,
   output logic        d_stall,
   output logic        busy
);

   localparam int IDX_W = $clog2(BLOCK_WORDS);
   localparam int OFF_W = IDX_W + 1;
   localparam logic [15:0]    OFF_MASK = 16'((1 << OFF_W) - 1);
   localparam logic [IDX_W:0] ISS_MAX  = (IDX_W + 1)'(BLOCK_WORDS);
   localparam logic [IDX_W-1:0] RCV_LAST = IDX_W'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      FILL  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_r, state_s;
   logic [15:0]        base_r, base_s;
   logic               tgt_d_r, tgt_d_s;
   logic [IDX_W:0]     iss_r, iss_s;
   logic [IDX_W-1:0]   rcv_r, rcv_s;

   function automatic logic [15:0] block_base(input logic [15:0] addr);
      block_base = addr & ~OFF_MASK;
   endfunction

   // Stalls follow the requesters directly so they drop in the cycle the request is served.
   assign i_stall = rst & icache_miss;
   assign d_stall = rst & ((dcache_rd & dcache_miss) | (dcache_wr & (state_r != WRITE)));
   assign busy    = (state_r != IDLE);

   // State, grant latches and burst counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         base_r  <= 16'h0000;
         tgt_d_r <= 1'b0;
         iss_r   <= '0;
         rcv_r   <= '0;
      end else begin
         state_r <= state_s;
         base_r  <= base_s;
         tgt_d_r <= tgt_d_s;
         iss_r   <= iss_s;
         rcv_r   <= rcv_s;
      end
   end

   // Arbitration, burst sequencing and memory/cache strobes.
   always_comb begin
      state_s     = state_r;
      base_s      = base_r;
      tgt_d_s     = tgt_d_r;
      iss_s       = iss_r;
      rcv_s       = rcv_r;
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = 16'h0000;
      mem_wdata   = 16'h0000;
      fill_addr   = 16'h0000;
      fill_data   = 16'h0000;
      i_load_data = 1'b0;
      i_load_tag  = 1'b0;
      d_load_data = 1'b0;
      d_load_tag  = 1'b0;
      case (state_r)
         IDLE: begin
            iss_s = '0;
            rcv_s = '0;
            if (dcache_wr) begin
               state_s = WRITE;
            end else if (dcache_rd && dcache_miss) begin
               state_s = FILL;
               tgt_d_s = 1'b1;
               base_s  = block_base(dcache_addr);
            end else if (icache_miss) begin
               state_s = FILL;
               tgt_d_s = 1'b0;
               base_s  = block_base(icache_addr);
            end else begin
               state_s = IDLE;
            end
         end
         WRITE: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = dcache_addr;
            mem_wdata = dcache_wdata;
            state_s   = IDLE;
         end
         FILL: begin
            // Issue and receive run independently so any memory latency overlaps the burst.
            if (iss_r < ISS_MAX) begin
               mem_en   = 1'b1;
               mem_addr = base_r | (16'(iss_r) << 1);
               iss_s    = iss_r + (IDX_W + 1)'(1);
            end else begin
               iss_s = iss_r;
            end
            if (mem_data_valid) begin
               fill_data   = mem_data_in;
               fill_addr   = base_r | (16'(rcv_r) << 1);
               i_load_data = ~tgt_d_r;
               d_load_data = tgt_d_r;
               rcv_s       = rcv_r + IDX_W'(1);
               if (rcv_r == RCV_LAST) begin
                  i_load_tag = ~tgt_d_r;
                  d_load_tag = tgt_d_r;
                  state_s    = DONE;
               end else begin
                  state_s = FILL;
               end
            end else begin
               rcv_s = rcv_r;
            end
         end
         DONE: begin
            // Quiet cycle so the freshly written tag clears the cache's miss signal.
            iss_s   = '0;
            rcv_s   = '0;
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss and write-through controller between the I-cache, the D-cache and the single shared 16-bit main-memory port. It arbitrates between I-cache read misses, D-cache read misses and D-cache stores. It sequences the 8-transfer burst that refills one 16-byte cache block and drives each cache's `load_data` and `load_tag` strobes. D-cache stores are write-through and no-write-allocate: a store only writes memory, and the cache updates itself on a hit.

## Interface

**Parameters**
- `BLOCK_WORDS`, default 8: 16-bit words per block. Must be a power of two, 2..8. The block base is the address with its low log2(BLOCK_WORDS)+1 bits cleared, so 0xFFF0 for 8 words.

**Ports** (name, direction, width, meaning)
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-low. All state and outputs clear immediately while it is low.
- `icache_miss` in 1: I-cache `cache_miss`.
- `icache_addr` in 16: I-cache lookup address.
- `dcache_miss` in 1: D-cache `cache_miss`.
- `dcache_rd` in 1: D-cache load request.
- `dcache_wr` in 1: D-cache store request.
- `dcache_addr` in 16: D-cache lookup address.
- `dcache_wdata` in 16: store data.
- `mem_en` out 1: memory request valid.
- `mem_wr` out 1: memory request is a write.
- `mem_addr` out 16: memory request address.
- `mem_wdata` out 16: memory write data.
- `mem_data_in` in 16: memory read data.
- `mem_data_valid` in 1: `mem_data_in` is valid this cycle.
- `fill_addr` out 16: address driven to the target cache during a fill.
- `fill_data` out 16: data driven to the target cache during a fill.
- `i_load_data` out 1: I-cache `load_data` strobe.
- `i_load_tag` out 1: I-cache `load_tag` strobe.
- `d_load_data` out 1: D-cache `load_data` strobe.
- `d_load_tag` out 1: D-cache `load_tag` strobe.
- `i_stall` out 1: stall the fetch stage.
- `d_stall` out 1: stall the memory stage.
- `busy` out 1: controller is not IDLE.

## Operation

**States:** IDLE, WRITE, FILL, DONE.

**Arbitration.** Requests are sampled in IDLE only, with fixed priority:
1. D store (`dcache_wr`).
2. D read miss (`dcache_rd & dcache_miss`).
3. I miss (`icache_miss`).

**Grant latches.**
- The target: I or D.
- The block base: requester address & 0xFFF0.

Requesters hold their request and address stable until their stall drops.

**WRITE (one cycle).**
- `mem_en=1`, `mem_wr=1`, `mem_addr=dcache_addr`, `mem_wdata=dcache_wdata`.
- Next state is IDLE.

**FILL.** Uses an issue counter `iss` (0..8) and a receive counter `rcv` (0..7).
- Issue side:
  - While `iss<8`: `mem_en=1`, `mem_wr=0`, `mem_addr=base|(iss<<1)`, then `iss++`.
  - At `iss==8`: `mem_en=0`.
- Receive side, on each `mem_data_valid`:
  - `fill_data=mem_data_in` and `fill_addr=base|(rcv<<1)`.
  - The target's `load_data` is pulsed for that cycle.
  - `rcv` increments.
- Last word: on `mem_data_valid` with `rcv==7`, the target's `load_tag` also pulses in that same cycle, and the next state is DONE.

**DONE (one cycle, no memory activity).** Lets the written tag become visible so the cache's miss signal deasserts. Next state is IDLE.

**Output rules.**
- `fill_addr`, `fill_data` and `mem_addr`/`mem_wdata` read 0 when unused.
- The load strobes are only ever asserted toward the latched target.

**Stalls.**
- `i_stall = icache_miss`.
- `d_stall = (dcache_rd & dcache_miss) | (dcache_wr & ~(state==WRITE))`.

**Boundaries.**
- `mem_data_valid` outside FILL, or after `rcv` has reached 7, is ignored.
- Simultaneous I and D requests: D is served first. The I request is then served from IDLE on a later cycle.
- Reset during FILL returns to IDLE with counters cleared and no `load_tag`. The partially filled block stays invalid, so the requester misses again and a fresh fill is issued. Late memory responses are ignored.

## Timing

- **Reset values:** all outputs 0, state IDLE, counters 0.
- **Memory model:** one request per cycle, with `mem_data_valid` returned L cycles after the request (L=4 nominal). The controller tolerates any L ≥ 1 and gaps in `mem_data_valid`.
- **Fill sequence:** grant edge at cycle 0; issues in cycles 1–8; last data and `load_tag` in cycle 8+L; DONE in cycle 9+L; back in IDLE at cycle 10+L. With L=4 a fill takes 14 cycles.
- **Store:** a store takes one WRITE cycle; a new arbitration happens in the following IDLE cycle.
- **Back-to-back:** with IDLE as the only arbitration point, there is a minimum of one IDLE cycle between operations.

## Test plan

- **I miss, single fill.** `icache_addr=0x1234`, L=4.
  - Reads go to 0x1230, 0x1232, …, 0x123E in cycles 1–8.
  - `i_load_data` asserts 8 times with `fill_addr` 0x1230..0x123E.
  - `i_load_tag` asserts with the 8th word in cycle 12.
  - `busy` is low at cycle 14.
- **D store.** `dcache_wr=1`, addr 0x00A0, data 0xBEEF.
  - One cycle of `mem_en=1`, `mem_wr=1`, 0x00A0/0xBEEF.
  - `d_stall` is high in the arbitration cycle and low in the WRITE cycle.
  - No load strobes.
- **Simultaneous D read miss and I miss.** D at 0x4000, I at 0x8000 in the same cycle.
  - The D fill for 0x4000 completes with `d_load_tag` first.
  - The I fill for 0x8000 follows after at least one IDLE cycle.
- **Irregular returns.** Valid pulses at random gaps, L=6.
  - Still exactly 8 `load_data` pulses, in address order.
  - `load_tag` only on the 8th; no extra memory issues.
- **Reset mid-fill.** `rst` low after 3 words are received.
  - All outputs go to 0 immediately and `load_tag` never pulses.
  - Stray `mem_data_valid` after reset causes no strobes.
  - Re-asserted `icache_miss` restarts a full 8-word fill.
